// File: rtl/call_ret_ctrl.sv
// call_ret_ctrl
// Sequences call/return requests against an external return-address stack.
// A call pushes pc+1, a return pops the top entry and presents it as a
// one-cycle ret_valid pulse, and a flush clears the stack. The controller
// mirrors the stack occupancy so it can refuse pushes when full (overflow)
// and pops when empty (underflow). Error flags are sticky until err_clr.
//
// Handshake: requests (call/ret/flush) are sampled only in a cycle where
// ready=1. A request sampled while ready=0 is dropped and never queued. All
// stack strobes (push/pop/stk_clr) and ret_valid are registered one-cycle
// pulses, and at most one stack strobe is high in any cycle.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   call, ret, flush  : requests (priority flush > call > ret)
//   pc                : PC of the calling instruction
//   stk_top           : current top entry of the external stack
//   err_clr           : clears overflow/underflow/conflict
//   ready             : high when a request is accepted this cycle
//   push, pop, stk_clr: stack strobes
//   stk_din           : data written to the stack on push
//   ret_valid         : return-target pulse, ret_target is its value
//   depth             : mirrored stack occupancy 0..DEPTH
//   overflow, underflow, conflict : sticky error flags
//   dbg_state_o       : current FSM state (IDLE=0, PUSH=1, POP=2, DONE=3)
module call_ret_ctrl #(
  parameter int AW    = 12,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          call,
  input  logic          ret,
  input  logic          flush,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] stk_top,
  input  logic          err_clr,
  output logic          ready,
  output logic          push,
  output logic          pop,
  output logic          stk_clr,
  output logic [AW-1:0] stk_din,
  output logic          ret_valid,
  output logic [AW-1:0] ret_target,
  output logic [3:0]    depth,
  output logic          overflow,
  output logic          underflow,
  output logic          conflict,
  output logic [1:0]    dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PUSH = 2'd1,
    S_POP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  state_e state_q, state_d;

  logic          push_q, push_d;
  logic          pop_q, pop_d;
  logic          stk_clr_q, stk_clr_d;
  logic          ret_valid_q, ret_valid_d;
  logic [AW-1:0] stk_din_q, stk_din_d;
  logic [AW-1:0] ret_target_q, ret_target_d;
  logic [3:0]    depth_q, depth_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          conflict_q, conflict_d;

  // Request decode, only meaningful in IDLE.
  logic idle, do_flush, do_call, do_ret, full, empty;

  assign idle     = (state_q == S_IDLE);
  assign do_flush = idle & flush;
  assign do_call  = idle & ~flush & call;
  assign do_ret   = idle & ~flush & ~call & ret;
  assign full     = (depth_q == DEPTH_L);
  assign empty    = (depth_q == 4'd0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        // Flush passes through DONE so ready is low in the stk_clr cycle.
        if (do_flush)               state_d = S_DONE;
        else if (do_call && !full)  state_d = S_PUSH;
        else if (do_ret && !empty)  state_d = S_POP;
        else if (do_ret)            state_d = S_DONE;
        else                        state_d = S_IDLE;
      end
      S_PUSH:  state_d = S_IDLE;
      S_POP:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready       = idle;
    dbg_state_o = state_q;
  end

  // Datapath next-state
  always_comb begin
    push_d       = do_call & ~full;
    pop_d        = do_ret & ~empty;
    stk_clr_d    = do_flush;
    // Popped target is captured in POP and shown one cycle later, giving
    // the stack output a cycle to settle; an empty pop answers at once.
    ret_valid_d  = (state_q == S_POP) | (do_ret & empty);
    stk_din_d    = stk_din_q;
    ret_target_d = ret_target_q;
    depth_d      = depth_q;

    if (do_call && !full) stk_din_d = pc + AW'(1);

    if (state_q == S_POP)      ret_target_d = stk_top;
    else if (do_ret && empty)  ret_target_d = '0;

    if (do_flush)                depth_d = 4'd0;
    else if (state_q == S_PUSH)  depth_d = depth_q + 4'd1;
    else if (state_q == S_POP)   depth_d = depth_q - 4'd1;

    // A new error in the err_clr cycle wins over the clear.
    overflow_d  = (overflow_q  & ~err_clr) | (do_call & full);
    underflow_d = (underflow_q & ~err_clr) | (do_ret & empty);
    conflict_d  = (conflict_q  & ~err_clr) | (do_call & ret);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      push_q       <= 1'b0;
      pop_q        <= 1'b0;
      stk_clr_q    <= 1'b1;
      ret_valid_q  <= 1'b0;
      stk_din_q    <= '0;
      ret_target_q <= '0;
      depth_q      <= 4'd0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      conflict_q   <= 1'b0;
    end else begin
      push_q       <= push_d;
      pop_q        <= pop_d;
      stk_clr_q    <= stk_clr_d;
      ret_valid_q  <= ret_valid_d;
      stk_din_q    <= stk_din_d;
      ret_target_q <= ret_target_d;
      depth_q      <= depth_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      conflict_q   <= conflict_d;
    end
  end

  assign push       = push_q;
  assign pop        = pop_q;
  assign stk_clr    = stk_clr_q;
  assign ret_valid  = ret_valid_q;
  assign stk_din    = stk_din_q;
  assign ret_target = ret_target_q;
  assign depth      = depth_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign conflict   = conflict_q;

endmodule
